// File: rtl/ct_spsram_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : ct_spsram_rr_arb2
//  Description : Two-requester round-robin arbiter. Bit 0 is the read port,
//                bit 1 the write port. Grants are combinational; a one-bit
//                last-winner register alternates priority under contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_spsram_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_b_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = write won the last grant, so read is favoured next; reset favours read
  logic last_wr_q;
  logic last_wr_d;

  // Grant a lone requester directly; on contention grant whoever lost last
  always_comb begin
    gnt_o     = 2'b00;
    last_wr_d = last_wr_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_wr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o != 2'b00) begin
      last_wr_d = gnt_o[1];
    end
  end

  // Last-winner pointer moves only when something is granted
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      last_wr_q <= 1'b1;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ct_spsram_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ct_spsram_arb_ctrl
//  Description : Single-port SRAM controller. After reset it zero-fills the
//                whole array, then arbitrates one write port and one read
//                port round-robin onto the SRAM pins (one-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic                  ST_INIT  = 1'b0;
  localparam logic                  ST_RUN   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  logic                  state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;
  logic                  rd_vld_q;
  logic                  run_w;
  logic                  clearing_w;
  logic [1:0]            arb_req_w;
  logic [1:0]            arb_gnt_w;

  // RUN implies reset is released (async reset forces INIT); the clear drive
  // is additionally gated so the SRAM is deselected while reset is held
  assign run_w      = (state_q == ST_RUN);
  assign clearing_w = (state_q == ST_INIT) && cpurst_b;

  // Zero-fill sweep, then a permanent move to RUN with init_done raised
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Requests are invisible to the arbiter until the clear has finished
  assign arb_req_w = {wr_req & run_w, rd_req & run_w};

  ct_spsram_rr_arb2 u_arb (
    .clk_i   (forever_cpuclk),
    .rst_b_i (cpurst_b),
    .req_i   (arb_req_w),
    .gnt_o   (arb_gnt_w)
  );

  assign wr_gnt = arb_gnt_w[1];
  assign rd_gnt = arb_gnt_w[0];

  // SRAM pin mux: clear sweep, granted write, granted read, or idle
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
    if (clearing_w) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = cnt_q;
    end else if (wr_gnt) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = ~wr_mask;
      ram_a    = wr_addr;
      ram_d    = wr_data;
    end else if (rd_gnt) begin
      ram_cen  = 1'b0;
      ram_a    = rd_addr;
    end
  end

  // Read data is valid exactly one cycle after each read grant
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_gnt;
    end
  end

  assign rd_vld    = rd_vld_q;
  assign rd_data   = rd_vld_q ? ram_q : '0;
  assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_spsram_arb_ctrl
//  Description : Self-checking bench for ct_spsram_arb_ctrl with an SRAM
//                array model, a transaction-level reference and directed plus
//                randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_spsram_arb_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 144;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] wr_mask = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          init_done;
  logic [AW-1:0] ram_a;
  logic          ram_cen;
  logic          ram_gwen;
  logic [DW-1:0] ram_wen;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  ct_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_gnt         (wr_gnt),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .init_done      (init_done),
    .ram_a          (ram_a),
    .ram_cen        (ram_cen),
    .ram_gwen       (ram_gwen),
    .ram_wen        (ram_wen),
    .ram_d          (ram_d),
    .ram_q          (ram_q)
  );

  // Single-port SRAM with bit write enables and one-cycle read latency
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, DW'(act), DW'(exp));
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // ---------------- reference model ----------------
  int            m_cnt     = 0;
  bit            m_done    = 1'b0;
  bit            m_last_wr = 1'b1;
  bit            m_pend    = 1'b0;
  logic [DW-1:0] m_pdata   = '0;
  logic [DW-1:0] m_mem [DEPTH];

  // Every cycle: check outputs against the model, then advance the model
  always @(negedge clk) begin
    bit ew, er;
    if (!rst_b) begin
      chkb("rst_cen", ram_cen, 1'b1);
      chkb("rst_wr_gnt", wr_gnt, 1'b0);
      chkb("rst_rd_gnt", rd_gnt, 1'b0);
      chkb("rst_rd_vld", rd_vld, 1'b0);
      chkb("rst_init_done", init_done, 1'b0);
      m_cnt = 0; m_done = 1'b0; m_last_wr = 1'b1; m_pend = 1'b0;
    end else if (!m_done) begin
      chkb("init_done_low", init_done, 1'b0);
      chkb("init_wr_gnt", wr_gnt, 1'b0);
      chkb("init_rd_gnt", rd_gnt, 1'b0);
      chkb("init_cen", ram_cen, 1'b0);
      chkb("init_gwen", ram_gwen, 1'b0);
      chk("init_wen", ram_wen, '0);
      chk("init_d", ram_d, '0);
      chk("init_addr", DW'(ram_a), DW'(m_cnt));
      chkb("init_rd_vld", rd_vld, 1'b0);
      m_mem[m_cnt] = '0;
      if (m_cnt == DEPTH - 1) m_done = 1'b1;
      m_cnt++;
    end else begin
      ew = 1'b0; er = 1'b0;
      if (wr_req && rd_req) begin
        if (m_last_wr) er = 1'b1; else ew = 1'b1;
      end else begin
        ew = wr_req; er = rd_req;
      end
      chkb("run_init_done", init_done, 1'b1);
      chkb("run_wr_gnt", wr_gnt, ew);
      chkb("run_rd_gnt", rd_gnt, er);
      chkb("run_rd_vld", rd_vld, m_pend);
      chk("run_rd_data", rd_data, m_pend ? m_pdata : '0);
      if (ew) begin
        chkb("wr_cen", ram_cen, 1'b0);
        chkb("wr_gwen", ram_gwen, 1'b0);
        chk("wr_addr", DW'(ram_a), DW'(wr_addr));
        chk("wr_d", ram_d, wr_data);
        chk("wr_wen", ram_wen, ~wr_mask);
        m_mem[wr_addr] = (m_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        m_last_wr = 1'b1;
      end else if (er) begin
        chkb("rd_cen", ram_cen, 1'b0);
        chkb("rd_gwen", ram_gwen, 1'b1);
        chk("rd_wen", ram_wen, '1);
        chk("rd_addr", DW'(ram_a), DW'(rd_addr));
        m_pdata = m_mem[rd_addr];
        m_last_wr = 1'b0;
      end else begin
        chkb("idle_cen", ram_cen, 1'b1);
        chkb("idle_gwen", ram_gwen, 1'b1);
        chk("idle_wen", ram_wen, '1);
        chk("idle_addr", DW'(ram_a), '0);
        chk("idle_d", ram_d, '0);
      end
      m_pend = er;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges from release until init_done rises; bounded
  task automatic wait_init(input string nm);
    int n;
    n = -1;
    for (int k = 1; k <= DEPTH + 1000; k++) begin
      step();
      if (init_done) begin
        n = k;
        break;
      end
    end
    chk(nm, DW'(n), DW'(DEPTH));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    step();
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    chkb("dir_wr_gnt", wr_gnt, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    step();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    chkb("dir_rd_gnt", rd_gnt, 1'b1);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chkb("dir_rd_vld", rd_vld, 1'b1);
    chk("dir_rd_data", rd_data, exp);
  endtask

  initial begin
    logic [5:0] gw, gr;
    int         vld_cnt;
    bit         pw, pr;

    for (int i = 0; i < DEPTH; i++) sram[i] = rnd_word();
    repeat (3) step();
    rst_b = 1'b1;

    // Abort the clear at counter 100 and restart it with a read pending
    repeat (100) step();
    chk("abort_counter", DW'(ram_a), DW'(100));
    rst_b = 1'b0;
    step(); step();
    rd_req = 1'b1; rd_addr = 12'hFFF;
    rst_b = 1'b1;
    wait_init("init_latency_restart");
    @(negedge clk);
    chkb("early_read_gnt", rd_gnt, 1'b1);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chkb("early_read_vld", rd_vld, 1'b1);
    chk("early_read_data", rd_data, '0);

    // Full-mask write then read-after-write; partial mask over cleared word
    do_write(12'h005, 144'hA5, '1);
    do_read(12'h005, 144'hA5);
    do_write(12'h010, '1, 144'h00FF);
    do_read(12'h010, 144'h00FF);
    do_write(12'h030, rnd_word(), '0);
    do_read(12'h030, '0);
    do_write(12'h031, rnd_word(), '1);

    // Contention: both held for six cycles after a write won last
    step();
    wr_req = 1'b1; wr_addr = 12'h020; wr_data = rnd_word(); wr_mask = '1;
    rd_req = 1'b1; rd_addr = 12'h021;
    vld_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gw[i] = wr_gnt; gr[i] = rd_gnt;
      vld_cnt += int'(rd_vld);
      step();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    vld_cnt += int'(rd_vld);
    chk("rr_write_grants", DW'(gw), DW'(6'b101010));
    chk("rr_read_grants", DW'(gr), DW'(6'b010101));
    chk("rr_vld_pulses", DW'(vld_cnt), DW'(3));

    // Randomized traffic: hold until granted, occasional withdrawal
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      pw = wr_gnt; pr = rd_gnt;
      step();
      if (wr_req && (pw || $urandom_range(15) == 0)) wr_req = 1'b0;
      else if (!wr_req && $urandom_range(2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(15));
        wr_data = rnd_word();
        case ($urandom_range(3))
          0:       wr_mask = '0;
          1:       wr_mask = '1;
          default: wr_mask = rnd_word();
        endcase
      end
      if (rd_req && (pr || $urandom_range(15) == 0)) rd_req = 1'b0;
      else if (!rd_req && $urandom_range(2) == 0) begin
        rd_req  = 1'b1;
        rd_addr = AW'($urandom_range(15));
      end
    end

    // Reset mid-RUN with both requests asserted: full clear must rerun
    step();
    wr_req = 1'b1; wr_addr = 12'h003; wr_data = rnd_word(); wr_mask = '1;
    rd_req = 1'b1; rd_addr = 12'h003;
    rst_b = 1'b0;
    step(); step();
    rst_b = 1'b1;
    wait_init("init_latency_run_reset");
    step();
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ct_spsram_arb_ctrl.md
CT_SPSRAM_ARB_CTRL -- requirements
Module: ct_spsram_arb_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, the SRAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 144, the SRAM word width.
REQ-003 forever_cpuclk  in  1  single clock; every register SHALL be clocked on its rising edge.
REQ-004 cpurst_b  in  1  reset, asynchronous assert, active-low.
REQ-005 wr_req  in  1  write request; wr_addr  in  ADDR_WIDTH; wr_data  in  DATA_WIDTH; wr_mask  in  DATA_WIDTH, 1 = write that bit.
REQ-006 wr_gnt  out  1  write accepted this cycle.
REQ-007 rd_req  in  1  read request; rd_addr  in  ADDR_WIDTH; rd_gnt  out  1  read accepted this cycle.
REQ-008 rd_vld  out  1  read data valid; rd_data  out  DATA_WIDTH  read data.
REQ-009 init_done  out  1  SRAM clear finished; requests are accepted only while it is high.
REQ-010 ram_a  out  ADDR_WIDTH; ram_cen  out  1, active-low; ram_gwen  out  1, active-low global write enable; ram_wen  out  DATA_WIDTH, active-low bit write enables; ram_d  out  DATA_WIDTH; ram_q  in  DATA_WIDTH. These connect to a single-port SRAM with one-cycle read latency.

Function
REQ-011 The FSM SHALL have exactly two states: INIT and RUN; reset state INIT.
REQ-012 INIT SHALL write all-zero data to addresses 0..2^ADDR_WIDTH-1, one per cycle, using an ADDR_WIDTH-bit counter: ram_cen=0, ram_gwen=0, ram_wen=all 0, ram_d=0, ram_a=counter.
REQ-013 When the counter equals 2^ADDR_WIDTH-1 in INIT, the FSM SHALL move to RUN on the next edge; init_done is registered and rises that edge, 2^ADDR_WIDTH cycles after reset release.
REQ-014 In INIT, wr_gnt and rd_gnt SHALL be 0 and requests SHALL be ignored, not queued.
REQ-015 In RUN, the arbiter SHALL grant at most one requester per cycle; grants SHALL be combinational from the requests and the priority pointer.
REQ-016 Arbitration SHALL be round-robin: a one-bit last-winner register; with both requests pending, the requester that did not win last SHALL be granted; after reset the pointer favours read.
REQ-017 A lone request SHALL be granted in the same cycle; the pointer SHALL update only on a grant.
REQ-018 Write grant: ram_cen=0, ram_gwen=0, ram_a=wr_addr, ram_d=wr_data, ram_wen=~wr_mask. A wr_mask of all 0 SHALL still issue the access, with no bits written.
REQ-019 Read grant: ram_cen=0, ram_gwen=1, ram_wen=all 1, ram_a=rd_addr.
REQ-020 With no grant in RUN: ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0.
REQ-021 rd_vld SHALL be a register set the cycle after rd_gnt, high for exactly one cycle per grant. rd_data SHALL equal ram_q while rd_vld=1 and SHALL be 0 otherwise.
REQ-022 Back-to-back read grants SHALL produce rd_vld on consecutive cycles.
REQ-023 A read granted the cycle after a write to the same address SHALL return the newly written bits.
REQ-024 A requester SHALL hold req and its payload until gnt; a req dropped before gnt SHALL be treated as withdrawn.

Reset
REQ-025 While cpurst_b=0, the block SHALL hold: state=INIT, counter=0, pointer=read-favoured, rd_vld=0, init_done=0.
REQ-026 A reset asserted mid-INIT or mid-RUN SHALL abort immediately; a full clear SHALL restart after release.
REQ-027 During reset, the combinational outputs SHALL be ram_cen=1, wr_gnt=0, rd_gnt=0.

Structure
REQ-028 No shared package SHALL be used; the state encoding is a local two-value parameter.
REQ-029 The round-robin arbiter SHALL be one sub-module, ct_spsram_rr_arb2: 2 requests in, 2 one-hot grants out, owning the pointer register.
REQ-030 The block SHALL contain no SRAM storage.

Verification
REQ-031 Release reset, no requests -> init_done rises exactly 4096 cycles later; every address 0..4095 is written once with zero; gnts stay 0 throughout.
REQ-032 Write addr 0x005, data 0x...A5, mask all 1; read 0x005 next cycle -> rd_vld the following cycle, rd_data=0x...A5.
REQ-033 Write 0x010 with mask=0x00FF, data all 1, over a cleared RAM; then read 0x010 -> rd_data=0x00FF.
REQ-034 wr_req and rd_req held high for 6 cycles after init -> grant order R,W,R,W,R,W; 3 rd_vld pulses.
REQ-035 cpurst_b pulsed low at INIT counter=100 -> restart from 0, init_done after a further 4096 cycles.
REQ-036 Read requested at addr 0xFFF before init_done -> no grant until RUN, then granted, rd_data=0.
